fifo_arbiter: RTL and testbench
===============================

FIFO_ARBITER -- requirements
Module: fifo_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- BITNUMBER, 6, data word width.
- NUM_REQ, 4, number of requester FIFOs.
- BURST, 4, maximum pops per grant.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- reset, in, 1, synchronous, active-low reset.
- fifo_empty, in, NUM_REQ, per-requester FIFO empty flag.
- fifo_valid, in, NUM_REQ, per-requester read-data-valid.
- fifo_data, in, NUM_REQ*BITNUMBER, per-requester read data; slice i is requester i.
- out_pause, in, 1, downstream backpressure (almost_full or pause).
- fifo_rd, out, NUM_REQ, one-hot pop strobe to the requester FIFOs.
- data_out, out, BITNUMBER, forwarded word.
- push, out, 1, data_out valid and written downstream this cycle.
- grant, out, 2, index of the granted requester.
- busy, out, 1, high when the state is not IDLE.
REQ-003 Reset SHALL be synchronous and active-low: sampled only on the clk rising edge, asserted when reset==0.

Function
REQ-004 FSM states SHALL be IDLE, POP, GAP and DRAIN, with all outputs registered.
- REQ-005 In IDLE, the arbiter SHALL scan round-robin starting from (last_grant+1) mod NUM_REQ. It selects the first i with fifo_empty[i]==0, loads grant=i, clears pop_cnt and goes to POP. If no FIFO is non-empty, it stays in IDLE.
- REQ-006 In POP, if out_pause==0 and fifo_empty[grant]==0, fifo_rd[grant] SHALL be 1 for exactly one cycle, pop_cnt SHALL increment, and the next state SHALL be GAP.
- REQ-007 In GAP, fifo_rd SHALL be 0, because FIFO flags lag one cycle; back-to-back pops are forbidden. The next state SHALL be POP if pop_cnt<BURST, else DRAIN.
- REQ-008 In POP, if fifo_empty[grant]==1 the next state SHALL be DRAIN with no pop. If out_pause==1 the FSM SHALL hold in POP with no pop.
- REQ-009 In DRAIN, the FSM SHALL wait until outstanding==0, then set last_grant=grant and go to IDLE.
REQ-010 The outstanding counter SHALL be 2 bits wide: +1 on each pop, -1 on each fifo_valid[grant]; a simultaneous pop and valid leaves it unchanged.
REQ-011 When fifo_valid[grant]==1, the next cycle SHALL give push=1 and data_out=fifo_data[grant]. A fifo_valid on a non-granted index SHALL be ignored.
REQ-012 push SHALL be forwarded even while out_pause==1, since backpressure stops new pops only; downstream headroom is at least 2.
REQ-013 pop_cnt SHALL be $clog2(BURST)+1 bits wide, and its compare SHALL be exact with no wrap.
REQ-014 At most one fifo_rd bit SHALL be set in any cycle.
REQ-015 fifo_rd SHALL never be asserted to a FIFO whose fifo_empty is 1 in that same cycle.
REQ-016 last_grant SHALL wrap from NUM_REQ-1 to 0.

Reset
REQ-017 On reset==0 the following SHALL be cleared:
- state=IDLE
- fifo_rd=0, push=0, data_out=0
- grant=0, busy=0
- last_grant=NUM_REQ-1, so requester 0 is scanned first
- pop_cnt=0, outstanding=0
REQ-018 Reset mid-burst SHALL abort immediately. In-flight fifo_valid in the cycle after release SHALL NOT produce push.

Configuration
REQ-019 With ARB_GRANT_CNT_EN defined:
- output grant_cnt (NUM_REQ*8 bits) SHALL be added.
- each 8-bit field SHALL count pops per requester, saturating at 255.
- all fields SHALL be cleared by reset.
Without ARB_GRANT_CNT_EN, the port and its logic SHALL be absent.

Structure
REQ-020 A shared package SHALL hold the FSM state enum (IDLE, POP, GAP, DRAIN) and the default BURST and NUM_REQ constants.
REQ-021 The round-robin next-index search SHALL be a sub-module rr_pick, combinational, with inputs fifo_empty and last_grant and outputs grant_next and found.

Verification
REQ-022 After reset, FIFO1 holds 3 words and the rest are empty:
- grant=1.
- pops on cycles t, t+2, t+4.
- DRAIN follows FIFO1 going empty.
- 3 pushes with matching data.
REQ-023 All 4 FIFOs hold 8 words each:
- grant order SHALL be 0,1,2,3,0,...
- each grant performs exactly 4 pops.
REQ-024 out_pause held high for 5 cycles during POP:
- zero fifo_rd for those cycles.
- the burst resumes with pop_cnt preserved.
- no word is lost.
REQ-025 reset=0 on the cycle after a pop:
- all outputs return to reset values the next cycle.
- the returning fifo_valid produces no push.
REQ-026 A fifo_valid pulse on a non-granted index SHALL produce no push.
REQ-027 With ARB_GRANT_CNT_EN defined and 300 pops from FIFO2, grant_cnt[23:16] SHALL read 255.

Source files
------------

// File: rtl/fifo_arbiter_pkg.sv
// fifo_arbiter_pkg: shared FSM state type and default sizing for the FIFO arbiter.
package fifo_arbiter_pkg;
    localparam int NUM_REQ_DEF = 4;
    localparam int BURST_DEF   = 4;
    localparam int GRANT_W     = 2;
    typedef enum logic [1:0] {IDLE, POP, GAP, DRAIN} state_t;
endpackage

// File: rtl/fifo_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search for the first non-empty FIFO after last_grant.
module rr_pick import fifo_arbiter_pkg::*; #(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0] fifo_empty,
    input  logic [GRANT_W-1:0] last_grant,
    output logic [GRANT_W-1:0] grant_next,
    output logic               found
);
    always_comb begin
        grant_next = '0;
        found      = 1'b0;
        // Walk farthest-first so the nearest candidate after last_grant wins.
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (!fifo_empty[GRANT_W'((int'(last_grant) + k) % NUM_REQ)]) begin
                grant_next = GRANT_W'((int'(last_grant) + k) % NUM_REQ);
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fifo_arbiter.sv
// fifo_arbiter: round-robin burst arbiter popping requester FIFOs into one downstream stream.
// Defining ARB_GRANT_CNT_EN adds per-requester saturating pop counters on grant_cnt.
module fifo_arbiter import fifo_arbiter_pkg::*; #(
    parameter int BITNUMBER = 6,
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int BURST     = BURST_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             fifo_empty,
    input  logic [NUM_REQ-1:0]             fifo_valid,
    input  logic [NUM_REQ*BITNUMBER-1:0]   fifo_data,
    input  logic                           out_pause,
    output logic [NUM_REQ-1:0]             fifo_rd,
    output logic [BITNUMBER-1:0]           data_out,
    output logic                           push,
    output logic [GRANT_W-1:0]             grant,
    output logic                           busy
`ifdef ARB_GRANT_CNT_EN
    ,
    output logic [NUM_REQ*8-1:0]           grant_cnt
`endif
);
    localparam int CW = $clog2(BURST) + 1;
    localparam logic [CW-1:0] BURST_C = CW'(BURST);

    state_t               r_state, w_state_nx;
    logic [NUM_REQ-1:0]   r_fifo_rd, w_rd_nx;
    logic [GRANT_W-1:0]   r_grant, w_grant_nx, r_last_grant, w_last_nx, w_pick;
    logic [CW-1:0]        r_pop_cnt, w_cnt_nx;
    logic [1:0]           r_outstanding;
    logic [BITNUMBER-1:0] r_data_out;
    logic                 r_push, r_busy, w_found, w_pop, w_val;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .fifo_empty (fifo_empty),
        .last_grant (r_last_grant),
        .grant_next (w_pick),
        .found      (w_found)
    );

    // Only read data we asked for: stray or post-reset valids are dropped.
    assign w_pop = r_fifo_rd[r_grant];
    assign w_val = fifo_valid[r_grant] && (r_outstanding != 2'd0);

    always_comb begin
        w_state_nx = r_state;
        w_rd_nx    = '0;
        w_grant_nx = r_grant;
        w_cnt_nx   = r_pop_cnt;
        w_last_nx  = r_last_grant;
        case (r_state)
            IDLE: if (w_found) begin
                w_state_nx = POP;
                w_grant_nx = w_pick;
                w_cnt_nx   = '0;
            end
            POP: if (fifo_empty[r_grant]) begin
                w_state_nx = DRAIN;
            end else if (!out_pause) begin
                w_rd_nx[r_grant] = 1'b1;
                w_cnt_nx         = r_pop_cnt + 1'b1;
                w_state_nx       = GAP;
            end
            GAP: w_state_nx = (r_pop_cnt < BURST_C) ? POP : DRAIN;
            DRAIN: if (r_outstanding == 2'd0) begin
                w_state_nx = IDLE;
                w_last_nx  = r_grant;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_fifo_rd     <= '0;
            r_grant       <= '0;
            r_last_grant  <= GRANT_W'(NUM_REQ - 1);
            r_pop_cnt     <= '0;
            r_outstanding <= '0;
            r_push        <= 1'b0;
            r_data_out    <= '0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_fifo_rd     <= w_rd_nx;
            r_grant       <= w_grant_nx;
            r_last_grant  <= w_last_nx;
            r_pop_cnt     <= w_cnt_nx;
            r_outstanding <= r_outstanding + {1'b0, w_pop} - {1'b0, w_val};
            r_push        <= w_val;
            r_busy        <= (w_state_nx != IDLE);
            if (w_val) r_data_out <= fifo_data[r_grant*BITNUMBER +: BITNUMBER];
        end
    end

    assign fifo_rd  = r_fifo_rd;
    assign data_out = r_data_out;
    assign push     = r_push;
    assign grant    = r_grant;
    assign busy     = r_busy;

`ifdef ARB_GRANT_CNT_EN
    logic [7:0] r_gcnt [NUM_REQ];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!reset) r_gcnt[i] <= '0;
            else if (r_fifo_rd[i] && r_gcnt[i] != 8'hff) r_gcnt[i] <= r_gcnt[i] + 8'd1;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign grant_cnt[g*8 +: 8] = r_gcnt[g];
    end
`endif
endmodule

// File: tb/tb_fifo_arbiter.sv
// tb_fifo_arbiter: directed self-checking bench with behavioural requester FIFOs around fifo_arbiter.
module tb_fifo_arbiter;
    localparam int NR = 4;
    localparam int BW = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     fifo_empty, fifo_valid, fifo_rd;
    logic [NR*BW-1:0]  fifo_data;
    logic              out_pause, push, busy;
    logic [BW-1:0]     data_out;
    logic [1:0]        grant;
`ifdef ARB_GRANT_CNT_EN
    logic [NR*8-1:0]   grant_cnt;
`endif

    int total = 0, bad = 0, cyc = 0;
    int cnt [NR];
    int ptr [NR];
    int pops[$], pop_cyc[$], bursts[$];
    logic [BW-1:0] pushes[$];
    int burst_pops = 0, viol_hot = 0, viol_empty = 0;

    always #5 clk = ~clk;

    fifo_arbiter #(.BITNUMBER(BW), .NUM_REQ(NR), .BURST(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_valid (fifo_valid),
        .fifo_data  (fifo_data),
        .out_pause  (out_pause),
        .fifo_rd    (fifo_rd),
        .data_out   (data_out),
        .push       (push),
        .grant      (grant),
        .busy       (busy)
`ifdef ARB_GRANT_CNT_EN
        ,
        .grant_cnt  (grant_cnt)
`endif
    );

    function automatic logic [BW-1:0] word(int i, int s);
        return BW'((i << 4) | (s & 15));
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: FIFO model pops on the strobe seen at the edge, flags and valid follow.
    task automatic tick();
        logic [NR-1:0] rd_s;
        rd_s = fifo_rd;
        if ($countones(rd_s) > 1) viol_hot++;
        if ((rd_s & fifo_empty) != '0) viol_empty++;
        @(posedge clk);
        #1;
        cyc++;
        fifo_valid = '0;
        for (int i = 0; i < NR; i++) begin
            if (rd_s[i] && cnt[i] > 0) begin
                fifo_data[i*BW +: BW] = word(i, ptr[i]);
                ptr[i]++;
                cnt[i]--;
                fifo_valid[i] = 1'b1;
            end
            fifo_empty[i] = (cnt[i] == 0);
            if (rd_s[i]) begin
                pops.push_back(i);
                pop_cyc.push_back(cyc);
            end
        end
        if (rd_s != '0) burst_pops++;
        if (push) pushes.push_back(data_out);
        if (!busy && burst_pops > 0) begin
            bursts.push_back(burst_pops);
            burst_pops = 0;
        end
    endtask

    task automatic load(int i, int n);
        cnt[i] += n;
        fifo_empty[i] = 1'b0;
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        out_pause = 1'b0;
        fifo_valid = '0;
        fifo_empty = '1;
        for (int i = 0; i < NR; i++) begin
            cnt[i] = 0;
            ptr[i] = 0;
        end
        tick();
        tick();
        pops.delete();
        pop_cyc.delete();
        bursts.delete();
        pushes.delete();
        burst_pops = 0;
        reset = 1'b1;
    endtask

    task automatic wait_rd(int max, string tag);
        int n = 0;
        while (fifo_rd == '0 && n < max) begin
            tick();
            n++;
        end
        check(tag, n < max, 1);
    endtask

    task automatic drain(int max, string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(busy == 1'b0 && fifo_empty == '1) && n < max);
        check(tag, n < max, 1);
    endtask

    initial begin
        int n, p0;
        fifo_data = '0;
        reset_dut();
        check("rst_rd", fifo_rd, 0);
        check("rst_push", push, 0);
        check("rst_data", data_out, 0);
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);

        // Single requester, three words, rest empty.
        load(1, 3);
        tick();
        check("a_grant", grant, 1);
        check("a_busy", busy, 1);
        drain(100, "a_timeout");
        check("a_npops", pops.size(), 3);
        if (pops.size() == 3) begin
            check("a_gap1", pop_cyc[1] - pop_cyc[0], 2);
            check("a_gap2", pop_cyc[2] - pop_cyc[1], 2);
            for (int k = 0; k < 3; k++) check("a_pop_idx", pops[k], 1);
        end
        check("a_npush", pushes.size(), 3);
        for (int k = 0; k < pushes.size() && k < 3; k++) check("a_push_data", pushes[k], word(1, k));
        check("a_nburst", bursts.size(), 1);
        if (bursts.size() == 1) check("a_burst", bursts[0], 3);

        // All four requesters, eight words each: 0,1,2,3,0,1,2,3 with four pops per grant.
        reset_dut();
        for (int i = 0; i < NR; i++) load(i, 8);
        drain(500, "b_timeout");
        check("b_npops", pops.size(), 32);
        for (int k = 0; k < pops.size() && k < 32; k++) check("b_pop_idx", pops[k], (k / 4) % 4);
        check("b_npush", pushes.size(), 32);
        for (int k = 0; k < pushes.size() && k < 32; k++)
            check("b_push_data", pushes[k], word((k / 4) % 4, (k / 16) * 4 + k % 4));
        check("b_nburst", bursts.size(), 8);
        for (int k = 0; k < bursts.size() && k < 8; k++) check("b_burst", bursts[k], 4);

        // Backpressure for five cycles in the middle of a burst.
        reset_dut();
        load(0, 6);
        wait_rd(20, "c_first_rd");
        out_pause = 1'b1;
        p0 = pushes.size();
        for (int k = 0; k < 5; k++) begin
            tick();
            check("c_pause_rd", fifo_rd, 0);
        end
        check("c_pause_push", pushes.size() - p0, 1);
        out_pause = 1'b0;
        drain(200, "c_timeout");
        check("c_npops", pops.size(), 6);
        check("c_npush", pushes.size(), 6);
        for (int k = 0; k < pushes.size() && k < 6; k++) check("c_push_data", pushes[k], word(0, k));
        check("c_nburst", bursts.size(), 2);
        if (bursts.size() == 2) begin
            check("c_burst0", bursts[0], 4);
            check("c_burst1", bursts[1], 2);
        end

        // Reset asserted on the cycle after a pop; stale valid after release is dropped.
        reset_dut();
        load(1, 4);
        n = 0;
        while (!(pushes.size() >= 1 && fifo_rd != '0) && n < 50) begin
            tick();
            n++;
        end
        check("d_setup", n < 50, 1);
        check("d_data_before", data_out, word(1, 0));
        tick();
        reset = 1'b0;
        for (int i = 0; i < NR; i++) cnt[i] = 0;
        fifo_empty = '1;
        tick();
        check("d_rst_rd", fifo_rd, 0);
        check("d_rst_push", push, 0);
        check("d_rst_data", data_out, 0);
        check("d_rst_grant", grant, 0);
        check("d_rst_busy", busy, 0);
        reset = 1'b1;
        fifo_valid = 4'b0011;
        fifo_data[0 +: BW] = 6'h2a;
        fifo_data[BW +: BW] = 6'h15;
        tick();
        check("d_stale_push", push, 0);
        tick();
        check("d_idle_push", push, 0);
        check("d_idle_busy", busy, 0);

        // Valid on a non-granted index alongside the granted one.
        reset_dut();
        load(1, 2);
        wait_rd(20, "e_first_rd");
        check("e_grant", grant, 1);
        tick();
        fifo_valid[3] = 1'b1;
        fifo_data[3*BW +: BW] = 6'h3f;
        tick();
        check("e_push", push, 1);
        check("e_data", data_out, word(1, 0));
        drain(100, "e_timeout");
        check("e_npush", pushes.size(), 2);
        if (pushes.size() == 2) check("e_data1", pushes[1], word(1, 1));

`ifdef ARB_GRANT_CNT_EN
        // Counter saturation after 300 pops from requester 2.
        reset_dut();
        load(2, 300);
        drain(3000, "f_timeout");
        check("f_npops", pops.size(), 300);
        check("f_cnt2", grant_cnt[23:16], 255);
        check("f_cnt0", grant_cnt[7:0], 0);
`endif

        check("onehot_rd", viol_hot, 0);
        check("rd_on_empty", viol_empty, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
